// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_INST,
        GNT_DATA
    } grant_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_READ,
        OP_WRITE
    } op_t;

    localparam int CNT_W = 4;

    // A data request asserting both strobes is treated as a write.
    function automatic op_t data_op(input logic rd, input logic wr);
        if (wr) begin
            return OP_WRITE;
        end
        if (rd) begin
            return OP_READ;
        end
        return OP_NONE;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down counter: load, decrement, zero flag.
module mem_wait_counter
    import mem_arbiter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for instruction fetch and data ports.
// Build option: MEM_ARB_RR_EN enables round-robin, else data has priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout,
    output logic        busy
);

    localparam logic [CNT_W-1:0] LOAD_VAL =
        (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    grant_t      r_grant;
    op_t         r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    grant_t      w_win;
    logic        w_accept;
    logic        w_load;
    logic        w_dec;
    logic        w_zero;
    logic        w_access;

`ifdef MEM_ARB_RR_EN
    grant_t r_last;

    // On contention the port that did not win last time goes first.
    always_comb begin
        w_win = GNT_NONE;
        if (d_req && i_req) begin
            w_win = (r_last == GNT_DATA) ? GNT_INST : GNT_DATA;
        end else if (d_req) begin
            w_win = GNT_DATA;
        end else if (i_req) begin
            w_win = GNT_INST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= GNT_INST;
        end else if (w_accept) begin
            r_last <= w_win;
        end
    end
`else
    always_comb begin
        w_win = GNT_NONE;
        if (d_req) begin
            w_win = GNT_DATA;
        end else if (i_req) begin
            w_win = GNT_INST;
        end
    end
`endif

    mem_wait_counter #(
        .W(CNT_W)
    ) u_wait (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_load_val(LOAD_VAL),
        .i_dec     (w_dec),
        .o_zero    (w_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_win != GNT_NONE) begin
                    w_accept    = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = (LATENCY == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_zero) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address and write data stay latched after the access completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant <= GNT_NONE;
            r_op    <= OP_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_grant <= w_win;
            if (w_win == GNT_DATA) begin
                r_op    <= data_op(d_read, d_write);
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
            end else begin
                r_op   <= OP_READ;
                r_addr <= i_addr;
            end
        end else if (r_state == ST_ACCESS) begin
            r_grant <= GNT_NONE;
        end
    end

    assign w_access  = (r_state == ST_ACCESS);
    assign i_ready   = w_access && (r_grant == GNT_INST);
    assign d_ready   = w_access && (r_grant == GNT_DATA);
    assign mem_read  = w_access && (r_op == OP_READ);
    assign mem_write = w_access && (r_op == OP_WRITE);
    assign mem_addr  = r_addr;
    assign mem_din   = r_wdata;
    assign busy      = (r_state != ST_IDLE);
    assign i_rdata   = i_ready ? mem_dout : '0;
    assign d_rdata   = (d_ready && (r_op == OP_READ)) ? mem_dout : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one shared single-port memory between an instruction-fetch requester (read-only) and a data requester (read/write) for the multi-cycle CPU. Sits between the control unit and the unified memory, whose read is asynchronous and whose write commits on the rising clock edge. Adds a programmable number of wait states to emulate slow memory and returns a one-cycle ready pulse to the granted requester.

## Interface
- LATENCY, 2, wait-state cycles inserted before each access (0..15)
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- i_req  input  1  instruction read request; held high until i_ready
- i_addr  input  32  instruction byte address; stable while i_req high
- i_ready  output  1  one-cycle pulse: instruction access completes this cycle
- i_rdata  output  32  read data; valid only while i_ready, else 0
- d_req  input  1  data request; held high until d_ready
- d_read  input  1  data request is a read
- d_write  input  1  data request is a write
- d_addr  input  32  data byte address; stable while d_req high
- d_wdata  input  32  write data; stable while d_req high
- d_ready  output  1  one-cycle pulse: data access completes this cycle
- d_rdata  output  32  read data; valid only while d_ready, else 0
- mem_addr  output  32  address to memory (latched request address)
- mem_din  output  32  write data to memory
- mem_read  output  1  memory read enable
- mem_write  output  1  memory write enable
- mem_dout  input  32  asynchronous memory read data
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, WAIT, ACCESS.
- IDLE: if any req sampled high at an edge, latch winner's addr/wdata/op and grant; go to WAIT with count=LATENCY-1, or directly to ACCESS if LATENCY=0.
- WAIT: decrement count each edge; at count=0 go to ACCESS. Requests arriving in WAIT are ignored until IDLE.
- ACCESS: mem_read or mem_write high for exactly this cycle; granted port's ready high; rdata = mem_dout for reads. Next edge always returns to IDLE (one bubble between accesses).
- Arbitration (default): data wins when both reqs high in IDLE.
- d_req with d_write=1: write (d_write wins over d_read). d_req with neither: completes as no-op, d_ready pulses, no mem enable.
- Requests are not cancellable; dropping req before ready is a protocol violation, arbiter still completes the access.
- mem_addr/mem_din hold latched values in all states; reset value 0.
- Reset (any state, any time): state IDLE, count 0, grant cleared, all outputs 0; no write in flight is committed since mem_write is only high in ACCESS.

## Timing
- req high in cycle 0 -> ACCESS/ready in cycle LATENCY+1; requester may drop req at the edge ending that cycle.
- Throughput: one access per LATENCY+2 cycles.
- Write lands in memory at the edge ending the ACCESS cycle.
- ready never high for both ports in the same cycle; never high two consecutive cycles.
- All outputs combinational from registered state and latched values only (no input-to-output path except mem_dout -> rdata).

## Configuration
- MEM_ARB_RR_EN defined: round-robin; a last-grant register (reset: instruction) makes the port not granted last win when both pending.
- Undefined: fixed priority, data always wins; no last-grant register.

## Structure
- Shared package: state enum (IDLE/WAIT/ACCESS), grant encoding (GNT_NONE, GNT_INST, GNT_DATA), op encoding (OP_NONE, OP_READ, OP_WRITE).
- One sub-module: mem_wait_counter (load, decrement, zero flag, async reset), instantiated once.

## Test plan
- LATENCY=2, i_req addr 0x10, mem word 4 = 0xDEADBEEF -> i_ready and i_rdata=0xDEADBEEF in cycle 3, mem_read high only that cycle.
- d_req write addr 0x20 data 0x12345678, then i_req... read via d_req addr 0x20 -> d_rdata=0x12345678; mem_write pulsed exactly once.
- i_req and d_req both high in same cycle -> d_ready first, i_ready LATENCY+2 cycles later; with MEM_ARB_RR_EN and prior data grant -> i_ready first.
- LATENCY=0, back-to-back d_req reads -> d_ready in cycle 1, 3, 5; busy low in cycles 2, 4.
- reset asserted during WAIT of a write -> all outputs 0 immediately, mem_write never high, target word unchanged.
- d_req with d_read=d_write=0 -> d_ready pulses at cycle LATENCY+1, mem_read and mem_write stay 0, d_rdata=0.
